// File: rtl/radix4_frame_ctrl_pkg.sv
// Shared types and constants for the radix-4 frame sequencer and its DFT kernel.
package r4fft_pkg;

  localparam int N_PT   = 4;
  localparam int IDX_W  = 2;
  localparam int FILL_W = 3;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] BIN_X0 = 2'd0;
  localparam logic [IDX_W-1:0] BIN_X1 = 2'd1;
  localparam logic [IDX_W-1:0] BIN_X2 = 2'd2;
  localparam logic [IDX_W-1:0] BIN_X3 = 2'd3;

  localparam logic [FILL_W-1:0] FILL_LAST = 3'd3;
  localparam logic [FILL_W-1:0] FILL_FULL = 3'd4;

endpackage

// File: rtl/radix4_frame_ctrl_if.sv
// Sample-in / bin-out stream bundle for radix4_frame_ctrl.
interface radix4_frame_ctrl_if
  import r4fft_pkg::*;
#(
  parameter int SAMPLE_W = 1,
  parameter int OUT_W    = SAMPLE_W + 3
);
  // Both streams: a beat moves on a rising edge where valid && ready; once valid is
  // raised the sender holds valid and payload unchanged until that beat moves.
  logic                    s_valid;
  logic                    s_ready;
  logic [SAMPLE_W-1:0]     s_data;
  logic                    m_valid;
  logic                    m_ready;
  logic signed [OUT_W-1:0] m_real;
  logic signed [OUT_W-1:0] m_imag;
  logic [IDX_W-1:0]        m_idx;
  logic                    m_last;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_real, m_imag, m_idx, m_last
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_real, m_imag, m_idx, m_last
  );

endinterface

// File: rtl/radix4_frame_ctrl_kernel.sv
// Combinational 4-point DFT kernel on unsigned samples; bins are signed OUT_W complex values.
module r4_dft_kernel
  import r4fft_pkg::*;
#(
  parameter int SAMPLE_W = 1,
  parameter int OUT_W    = SAMPLE_W + 3
) (
  input  logic [N_PT-1:0][SAMPLE_W-1:0] i_x,
  output logic [N_PT-1:0][OUT_W-1:0]    o_re,
  output logic [N_PT-1:0][OUT_W-1:0]    o_im
);

  logic signed [OUT_W-1:0] w_x0, w_x1, w_x2, w_x3;

  assign w_x0 = {{(OUT_W-SAMPLE_W){1'b0}}, i_x[0]};
  assign w_x1 = {{(OUT_W-SAMPLE_W){1'b0}}, i_x[1]};
  assign w_x2 = {{(OUT_W-SAMPLE_W){1'b0}}, i_x[2]};
  assign w_x3 = {{(OUT_W-SAMPLE_W){1'b0}}, i_x[3]};

  // Twiddles are 1, -j, -1, j, so every bin is a signed sum of samples.
  always_comb begin
    o_re[0] = w_x0 + w_x1 + w_x2 + w_x3;
    o_im[0] = '0;
    o_re[1] = w_x0 - w_x2;
    o_im[1] = w_x3 - w_x1;
    o_re[2] = w_x0 - w_x1 + w_x2 - w_x3;
    o_im[2] = '0;
    o_re[3] = w_x0 - w_x2;
    o_im[3] = w_x1 - w_x3;
  end

endmodule

// File: rtl/radix4_frame_ctrl.sv
// Frame sequencer: collects 4 samples, latches the DFT kernel once, streams bins X0..X3.
// Optional macro R4_OVERLAP_EN lets the next frame's samples load while bins drain.
module radix4_frame_ctrl
  import r4fft_pkg::*;
#(
  parameter int SAMPLE_W = 1,
  parameter int OUT_W    = SAMPLE_W + 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  radix4_frame_ctrl_if.slave   bus,
  output logic                 busy,
  output state_t               o_dbg_state
);

  state_t                        r_state, w_state_nxt;
  logic [FILL_W-1:0]             r_fill_cnt, w_fill_nxt;
  logic [N_PT-1:0][SAMPLE_W-1:0] r_buf;
  logic [N_PT-1:0][OUT_W-1:0]    r_res_re, r_res_im;
  logic [N_PT-1:0][OUT_W-1:0]    w_k_re, w_k_im;
  logic [IDX_W-1:0]              r_idx;
  logic                          w_s_xfer, w_m_xfer;

  r4_dft_kernel #(
    .SAMPLE_W (SAMPLE_W),
    .OUT_W    (OUT_W)
  ) u_kernel (
    .i_x  (r_buf),
    .o_re (w_k_re),
    .o_im (w_k_im)
  );

  assign w_s_xfer = bus.s_valid && bus.s_ready;
  assign w_m_xfer = bus.m_valid && bus.m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FILL;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill_cnt + FILL_W'(w_s_xfer);
    case (r_state)
      FILL: begin
        if (w_s_xfer && (r_fill_cnt == FILL_LAST)) w_state_nxt = CALC;
      end
      CALC: begin
        w_state_nxt = DRAIN;
        w_fill_nxt  = '0;
      end
      DRAIN: begin
        if (w_m_xfer && (r_idx == BIN_X3)) begin
`ifdef R4_OVERLAP_EN
          // Decide on the count including a sample landing on this same edge.
          w_state_nxt = (w_fill_nxt == FILL_FULL) ? CALC : FILL;
`else
          w_state_nxt = FILL;
`endif
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_comb begin
    bus.s_ready = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_last  = 1'b0;
    case (r_state)
      FILL: bus.s_ready = 1'b1;
      DRAIN: begin
        bus.m_valid = 1'b1;
        bus.m_last  = (r_idx == BIN_X3);
`ifdef R4_OVERLAP_EN
        bus.s_ready = (r_fill_cnt < FILL_FULL);
`endif
      end
      default: ;
    endcase
  end

  assign bus.m_idx  = r_idx;
  assign bus.m_real = r_res_re[r_idx];
  assign bus.m_imag = r_res_im[r_idx];
  assign busy        = (r_state != FILL) || (r_fill_cnt != '0);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill_cnt <= '0;
      r_buf      <= '0;
      r_res_re   <= '0;
      r_res_im   <= '0;
      r_idx      <= '0;
    end else begin
      r_fill_cnt <= w_fill_nxt;
      if (w_s_xfer) r_buf[r_fill_cnt[IDX_W-1:0]] <= bus.s_data;
      if (r_state == CALC) begin
        r_res_re <= w_k_re;
        r_res_im <= w_k_im;
      end
      // Two-bit index wraps to bin 0 after the last bin.
      if (w_m_xfer) r_idx <= r_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_radix4_frame_ctrl.sv
// Self-checking bench for radix4_frame_ctrl; define R4_OVERLAP_EN to exercise overlapped framing.
module tb_radix4_frame_ctrl;
  import r4fft_pkg::*;

  localparam int SW = 1;
  localparam int OW = SW + 3;
  localparam int EW = 2 * OW + 3;
`ifdef R4_OVERLAP_EN
  localparam int  EXP_PERIOD    = 5;
  localparam int  EXP_GAP       = 2;
  localparam logic EXP_RDY_DRAIN = 1'b1;
`else
  localparam int  EXP_PERIOD    = 9;
  localparam int  EXP_GAP       = 6;
  localparam logic EXP_RDY_DRAIN = 1'b0;
`endif

  logic   clk = 1'b0;
  logic   rst_n;
  logic   busy;
  state_t dbg_state;
  int     total = 0;
  int     bad   = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  radix4_frame_ctrl_if #(.SAMPLE_W(SW), .OUT_W(OW)) ifc ();

  radix4_frame_ctrl #(.SAMPLE_W(SW), .OUT_W(OW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc.slave),
    .busy        (busy),
    .o_dbg_state (dbg_state)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: X[k] = sum_n x[n] * (-j)^(n*k), packed as {idx, last, re, im}.
  task automatic model_frame(input int x[4]);
    for (int k = 0; k < 4; k++) begin
      int re = 0;
      int im = 0;
      logic [OW-1:0] rv, iv;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0: re += x[n];
          1: im -= x[n];
          2: re -= x[n];
          default: im += x[n];
        endcase
      end
      rv = re[OW-1:0];
      iv = im[OW-1:0];
      exp_q.push_back({2'(k), (k == 3), rv, iv});
    end
  endtask

  task automatic rand_frame(output int x[4]);
    for (int n = 0; n < 4; n++) x[n] = int'($urandom_range(0, (1 << SW) - 1));
  endtask

  // Driver tasks are entered and left on a falling edge.
  task automatic push_sample(input int d, output bit ok);
    int n = 0;
    ok = 1'b0;
    ifc.s_valid = 1'b1;
    ifc.s_data  = SW'(d);
    while (!ifc.s_ready && n < 50) begin @(negedge clk); n++; end
    if (ifc.s_ready) begin @(posedge clk); ok = 1'b1; @(negedge clk); end
    ifc.s_valid = 1'b0;
  endtask

  task automatic send_frame(input int x[4], output bit ok);
    bit one;
    ok = 1'b1;
    for (int n = 0; n < 4; n++) begin
      push_sample(x[n], one);
      ok = ok & one;
    end
  endtask

  task automatic recv_bin(input int stall, output logic [EW-1:0] obs, output bit ok);
    int n = 0;
    ok = 1'b0;
    ifc.m_ready = 1'b0;
    repeat (stall) @(negedge clk);
    ifc.m_ready = 1'b1;
    while (!ifc.m_valid && n < 50) begin @(negedge clk); n++; end
    obs = {ifc.m_idx, ifc.m_last, ifc.m_real, ifc.m_imag};
    if (ifc.m_valid) begin ok = 1'b1; @(posedge clk); end
    @(negedge clk);
    ifc.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [EW+3:0] obs, want;
    obs  = {ifc.s_ready, ifc.m_valid, ifc.m_idx, ifc.m_last, ifc.m_real, ifc.m_imag, busy};
    want = {1'b1, 1'b0, 2'd0, 1'b0, {OW{1'b0}}, {OW{1'b0}}, 1'b0};
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL reset_outputs: got %h want %h", obs, want);
    end
    total++;
    if (dbg_state !== FILL) begin
      bad++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, FILL);
    end
  endtask

  task automatic test_known(input string name, input int x[4]);
    bit ok;
    logic [EW-1:0] obs, want;
    model_frame(x);
    send_frame(x, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL %s_accept: got ok=%0d want 1", name, ok); end
    for (int k = 0; k < 4; k++) begin
      recv_bin(0, obs, ok);
      want = exp_q.pop_front();
      total++;
      if (!ok || obs !== want) begin
        bad++;
        $display("FAIL %s_bin%0d: got %h (ok=%0d) want %h", name, k, obs, ok, want);
      end
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle: got busy=%b want 0", name, busy); end
  endtask

  task automatic test_latency();
    int x[4] = '{1, 1, 1, 1};
    bit ok;
    logic [EW-1:0] obs, want;
    model_frame(x);
    send_frame(x, ok);
    total++;
    if ({ok, ifc.m_valid, ifc.s_ready, busy} !== 4'b1001) begin
      bad++;
      $display("FAIL latency_calc: got ok,mv,sr,busy=%b want 1001", {ok, ifc.m_valid, ifc.s_ready, busy});
    end
    @(negedge clk);
    total++;
    if ({ifc.m_valid, ifc.m_idx} !== 3'b100) begin
      bad++;
      $display("FAIL latency_bin0: got mv,idx=%b want 100", {ifc.m_valid, ifc.m_idx});
    end
    for (int k = 0; k < 4; k++) begin
      recv_bin(0, obs, ok);
      want = exp_q.pop_front();
      total++;
      if (!ok || obs !== want) begin
        bad++;
        $display("FAIL dc_bin%0d: got %h (ok=%0d) want %h", k, obs, ok, want);
      end
    end
  endtask

  task automatic test_stall();
    int x[4];
    bit ok;
    logic [EW-1:0] obs, want, snap;
    rand_frame(x);
    model_frame(x);
    send_frame(x, ok);
    for (int k = 0; k < 2; k++) begin
      recv_bin(0, obs, ok);
      want = exp_q.pop_front();
      total++;
      if (!ok || obs !== want) begin
        bad++;
        $display("FAIL stall_pre_bin%0d: got %h want %h", k, obs, want);
      end
    end
    snap = {ifc.m_idx, ifc.m_last, ifc.m_real, ifc.m_imag};
    total++;
    if (!ifc.m_valid || snap !== exp_q[0]) begin
      bad++;
      $display("FAIL stall_bin2_shown: got %h mv=%b want %h", snap, ifc.m_valid, exp_q[0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      obs = {ifc.m_idx, ifc.m_last, ifc.m_real, ifc.m_imag};
      total++;
      if (obs !== snap || ifc.m_valid !== 1'b1 || ifc.s_ready !== EXP_RDY_DRAIN) begin
        bad++;
        $display("FAIL stall_hold%0d: got %h mv=%b sr=%b want %h mv=1 sr=%b",
                 c, obs, ifc.m_valid, ifc.s_ready, snap, EXP_RDY_DRAIN);
      end
    end
    recv_bin(0, obs, ok);
    want = exp_q.pop_front();
    total++;
    if (!ok || obs !== want) begin bad++; $display("FAIL stall_bin2: got %h want %h", obs, want); end
    total++;
    if ({ifc.m_valid, ifc.m_idx, ifc.m_last} !== 4'b1111) begin
      bad++;
      $display("FAIL stall_bin3_next: got mv,idx,last=%b want 1111", {ifc.m_valid, ifc.m_idx, ifc.m_last});
    end
    recv_bin(0, obs, ok);
    want = exp_q.pop_front();
    total++;
    if (!ok || obs !== want) begin bad++; $display("FAIL stall_bin3: got %h want %h", obs, want); end
  endtask

  task automatic test_reset_mid();
    int x[4];
    bit ok;
    logic [EW-1:0] obs, want;
    logic [EW+3:0] ro, rw;
    push_sample(1, ok);
    push_sample(1, ok);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    ro = {ifc.s_ready, ifc.m_valid, ifc.m_idx, ifc.m_last, ifc.m_real, ifc.m_imag, busy};
    rw = {1'b1, 1'b0, 2'd0, 1'b0, {OW{1'b0}}, {OW{1'b0}}, 1'b0};
    total++;
    if (ro !== rw) begin bad++; $display("FAIL midreset_outputs: got %h want %h", ro, rw); end
    @(negedge clk);
    rst_n = 1'b1;
    rand_frame(x);
    model_frame(x);
    send_frame(x, ok);
    for (int k = 0; k < 4; k++) begin
      recv_bin(0, obs, ok);
      want = exp_q.pop_front();
      total++;
      if (!ok || obs !== want) begin
        bad++;
        $display("FAIL midreset_bin%0d: got %h want %h", k, obs, want);
      end
    end
  endtask

  task automatic test_random();
    int x[4];
    bit ok;
    logic [EW-1:0] obs, want;
    for (int f = 0; f < 10; f++) begin
      rand_frame(x);
      model_frame(x);
      send_frame(x, ok);
      for (int k = 0; k < 4; k++) begin
        recv_bin(int'($urandom_range(0, 2)), obs, ok);
        want = exp_q.pop_front();
        total++;
        if (!ok || obs !== want) begin
          bad++;
          $display("FAIL random_f%0d_bin%0d: got %h want %h", f, k, obs, want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int smp[12];
    int fr[4];
    int last_cyc[3];
    int first_cyc[3];
    for (int f = 0; f < 3; f++) begin
      rand_frame(fr);
      model_frame(fr);
      for (int n = 0; n < 4; n++) smp[f*4 + n] = fr[n];
    end
    fork
      begin
        int i = 0;
        int n = 0;
        bit acc;
        while (i < 12 && n < 200) begin
          ifc.s_valid = 1'b1;
          ifc.s_data  = SW'(smp[i]);
          acc = ifc.s_ready;
          @(posedge clk);
          if (acc) i++;
          @(negedge clk);
          n++;
        end
        ifc.s_valid = 1'b0;
      end
      begin
        int got = 0;
        int n = 0;
        logic [EW-1:0] obs, want;
        ifc.m_ready = 1'b1;
        while (got < 12 && n < 300) begin
          @(negedge clk);
          n++;
          if (ifc.m_valid) begin
            obs  = {ifc.m_idx, ifc.m_last, ifc.m_real, ifc.m_imag};
            want = exp_q.pop_front();
            total++;
            if (obs !== want) begin
              bad++;
              $display("FAIL b2b_bin%0d: got %h want %h", got, obs, want);
            end
            if (got % 4 == 0) first_cyc[got/4] = n;
            if (got % 4 == 3) last_cyc[got/4] = n;
            got++;
          end
        end
        total++;
        if (got != 12) begin bad++; $display("FAIL b2b_count: got %0d bins want 12", got); end
        ifc.m_ready = 1'b0;
      end
    join
    for (int f = 1; f < 3; f++) begin
      total++;
      if (last_cyc[f] - last_cyc[f-1] != EXP_PERIOD) begin
        bad++;
        $display("FAIL b2b_period%0d: got %0d want %0d", f, last_cyc[f] - last_cyc[f-1], EXP_PERIOD);
      end
      total++;
      if (first_cyc[f] - last_cyc[f-1] != EXP_GAP) begin
        bad++;
        $display("FAIL b2b_gap%0d: got %0d want %0d", f, first_cyc[f] - last_cyc[f-1], EXP_GAP);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int imp[4]   = '{1, 0, 0, 0};
    int shift[4] = '{0, 1, 0, 0};
    rst_n       = 1'b0;
    ifc.s_valid = 1'b0;
    ifc.s_data  = '0;
    ifc.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_known("impulse", imp);
    test_latency();
    test_known("shift", shift);
    test_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
